// File: rtl/pwm_capture.sv
// PWM input capture: measures period (rise to rise) and active time (rise to fall)
// of an asynchronous input in clk cycles, with a valid/ack result handshake.
module pwm_capture #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cap_en,
  input  logic             pol,
  input  logic [CNT_W-1:0] timeout,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] meas_period,
  output logic [CNT_W-1:0] meas_high,
  output logic             meas_valid,
  input  logic             meas_ack,
  output logic             meas_overrun,
  output logic             meas_timeout,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t                 state_reg;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic [CNT_W-1:0]       high_tmp_reg;

  logic                   s;
  logic                   rise;
  logic                   fall;
  logic [CNT_W-1:0]       cnt_inc;
  logic                   to_hit;
  logic                   load;

  // Synchronizer chain: stage 0 samples the pin, each later stage samples the one before.
  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) sync_reg[gi] <= 1'b0;
          else        sync_reg[gi] <= pwm_in;
        end
      end else begin : g_next
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) sync_reg[gi] <= 1'b0;
          else        sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  assign s    = sync_reg[SYNC_STAGES-1] ^ pol;
  assign rise = s & ~prev_reg;
  assign fall = ~s & prev_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_reg <= 1'b0;
    else        prev_reg <= s;
  end

  always_comb begin
    cnt_inc = (&cnt_reg) ? cnt_reg : cnt_reg + CNT_ONE;
    to_hit  = (timeout != '0) && (cnt_reg == timeout) && !rise && !fall;
    load    = cap_en && (state_reg == LOW) && rise;
  end

  // Measurement FSM; a timeout abort returns to ARM so the next clean rise restarts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      high_tmp_reg <= '0;
      meas_timeout <= 1'b0;
    end else if (!cap_en) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      meas_timeout <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          state_reg <= ARM;
          cnt_reg   <= '0;
        end
        ARM: begin
          if (rise) begin
            state_reg <= HIGH;
            cnt_reg   <= CNT_ONE;
          end else begin
            cnt_reg <= '0;
          end
        end
        HIGH: begin
          if (fall) begin
            high_tmp_reg <= cnt_reg;
            state_reg    <= LOW;
            cnt_reg      <= cnt_inc;
          end else if (to_hit) begin
            state_reg    <= ARM;
            cnt_reg      <= '0;
            meas_timeout <= 1'b1;
          end else if (rise) begin
            cnt_reg <= CNT_ONE;
          end else begin
            cnt_reg <= cnt_inc;
          end
        end
        LOW: begin
          if (rise) begin
            state_reg <= HIGH;
            cnt_reg   <= CNT_ONE;
          end else if (to_hit) begin
            state_reg    <= ARM;
            cnt_reg      <= '0;
            meas_timeout <= 1'b1;
          end else begin
            cnt_reg <= cnt_inc;
          end
        end
        default: begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

  // Result handshake: a load always wins over a simultaneous ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meas_period  <= '0;
      meas_high    <= '0;
      meas_valid   <= 1'b0;
      meas_overrun <= 1'b0;
    end else if (load) begin
      meas_period <= cnt_reg;
      meas_high   <= high_tmp_reg;
      meas_valid  <= 1'b1;
      if (meas_valid && !meas_ack) meas_overrun <= 1'b1;
    end else if (meas_ack && meas_valid) begin
      meas_valid   <= 1'b0;
      meas_overrun <= 1'b0;
    end
  end

  assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: period/high measurement, polarity, timeout,
// overrun handshake, enable drop, saturation and asynchronous reset.
module tb_pwm_capture;

  logic        clk;
  logic        rst_n;
  logic        cap_en;
  logic        pol;
  logic [15:0] timeout;
  logic        pwm_in;
  logic [15:0] meas_period;
  logic [15:0] meas_high;
  logic        meas_valid;
  logic        meas_ack;
  logic        meas_overrun;
  logic        meas_timeout;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  pwm_capture #(.CNT_W(16), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cap_en       (cap_en),
    .pol          (pol),
    .timeout      (timeout),
    .pwm_in       (pwm_in),
    .meas_period  (meas_period),
    .meas_high    (meas_high),
    .meas_valid   (meas_valid),
    .meas_ack     (meas_ack),
    .meas_overrun (meas_overrun),
    .meas_timeout (meas_timeout),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    cap_en   = 1'b0;
    pol      = 1'b0;
    timeout  = 16'd0;
    pwm_in   = 1'b0;
    meas_ack = 1'b0;
    tick(3);
    chk("rst_period",  32'(meas_period),  32'd0);
    chk("rst_high",    32'(meas_high),    32'd0);
    chk("rst_valid",   32'(meas_valid),   32'd0);
    chk("rst_overrun", 32'(meas_overrun), 32'd0);
    chk("rst_timeout", 32'(meas_timeout), 32'd0);
    chk("rst_busy",    32'(busy),         32'd0);

    // 1: active-high, period 100, high 30, each result acknowledged
    rst_n = 1'b1;
    tick(1);
    cap_en = 1'b1;
    tick(2);
    chk("t1_busy", 32'(busy), 32'd1);
    pwm_in = 1'b1; tick(30); pwm_in = 1'b0; tick(70);
    for (int i = 0; i < 3; i++) begin
      pwm_in = 1'b1;
      tick(3);
      chk("t1_valid",  32'(meas_valid),  32'd1);
      chk("t1_period", 32'(meas_period), 32'd100);
      chk("t1_high",   32'(meas_high),   32'd30);
      meas_ack = 1'b1; tick(1); meas_ack = 1'b0;
      chk("t1_acked", 32'(meas_valid), 32'd0);
      tick(26);
      pwm_in = 1'b0;
      tick(69);
      chk("t1_one_per_period", 32'(meas_valid), 32'd0);
      tick(1);
    end
    $display("txn t1 pol=0 period=%0d high=%0d", meas_period, meas_high);

    // 2: same waveform, active-low polarity
    cap_en = 1'b0; tick(2);
    pol = 1'b1; tick(1);
    cap_en = 1'b1; tick(2);
    pwm_in = 1'b1; tick(30); pwm_in = 1'b0; tick(70);
    for (int i = 0; i < 2; i++) begin
      pwm_in = 1'b1; tick(30);
      pwm_in = 1'b0; tick(3);
      chk("t2_valid",  32'(meas_valid),  32'd1);
      chk("t2_period", 32'(meas_period), 32'd100);
      chk("t2_high",   32'(meas_high),   32'd70);
      meas_ack = 1'b1; tick(1); meas_ack = 1'b0;
      chk("t2_acked", 32'(meas_valid), 32'd0);
      tick(66);
    end
    $display("txn t2 pol=1 period=%0d high=%0d", meas_period, meas_high);

    // 3: timeout=50 with input stuck high after a rise
    cap_en = 1'b0; tick(2);
    pol = 1'b0; timeout = 16'd50; pwm_in = 1'b0; tick(3);
    cap_en = 1'b1; tick(2);
    pwm_in = 1'b1;
    tick(52);
    chk("t3_timeout_early", 32'(meas_timeout), 32'd0);
    tick(1);
    chk("t3_timeout", 32'(meas_timeout), 32'd1);
    chk("t3_busy",    32'(busy),         32'd1);
    chk("t3_valid",   32'(meas_valid),   32'd0);
    tick(10);
    chk("t3_no_result",  32'(meas_valid),   32'd0);
    chk("t3_sticky",     32'(meas_timeout), 32'd1);
    cap_en = 1'b0; tick(1);
    chk("t3_clear_on_disable", 32'(meas_timeout), 32'd0);
    chk("t3_idle",             32'(busy),         32'd0);
    $display("txn t3 timeout abort observed");

    // 4: overrun, ack colliding with a load, then a lone ack
    pwm_in = 1'b0; timeout = 16'd0; tick(3);
    cap_en = 1'b1; tick(2);
    pwm_in = 1'b1; tick(30); pwm_in = 1'b0; tick(70);
    pwm_in = 1'b1; tick(3);
    chk("t4_r1_valid",   32'(meas_valid),   32'd1);
    chk("t4_r1_overrun", 32'(meas_overrun), 32'd0);
    chk("t4_r1_period",  32'(meas_period),  32'd100);
    tick(17); pwm_in = 1'b0; tick(40);
    pwm_in = 1'b1; tick(3);
    chk("t4_r2_overrun", 32'(meas_overrun), 32'd1);
    chk("t4_r2_period",  32'(meas_period),  32'd60);
    chk("t4_r2_high",    32'(meas_high),    32'd20);
    tick(22); pwm_in = 1'b0; tick(55);
    pwm_in = 1'b1; tick(2);
    meas_ack = 1'b1; tick(1); meas_ack = 1'b0;
    chk("t4_r3_valid",   32'(meas_valid),   32'd1);
    chk("t4_r3_overrun", 32'(meas_overrun), 32'd1);
    chk("t4_r3_period",  32'(meas_period),  32'd80);
    chk("t4_r3_high",    32'(meas_high),    32'd25);
    meas_ack = 1'b1; tick(1); meas_ack = 1'b0;
    chk("t4_ack_valid",   32'(meas_valid),   32'd0);
    chk("t4_ack_overrun", 32'(meas_overrun), 32'd0);
    tick(21); pwm_in = 1'b0; tick(55);
    $display("txn t4 overrun handshake period=%0d high=%0d", meas_period, meas_high);

    // 5: cap_en dropped mid-HIGH, then re-enabled with the input already high
    pwm_in = 1'b1; tick(3);
    chk("t5_r4_period", 32'(meas_period), 32'd80);
    meas_ack = 1'b1; tick(1); meas_ack = 1'b0;
    tick(5);
    cap_en = 1'b0; tick(1);
    chk("t5_busy_off", 32'(busy), 32'd0);
    tick(20); pwm_in = 1'b0; tick(10);
    chk("t5_no_load",     32'(meas_valid),  32'd0);
    chk("t5_period_hold", 32'(meas_period), 32'd80);
    pwm_in = 1'b1; tick(5);
    cap_en = 1'b1; tick(2);
    chk("t5_rearmed", 32'(busy), 32'd1);
    pwm_in = 1'b0; tick(40);
    pwm_in = 1'b1; tick(3);
    chk("t5_first_rise_no_result", 32'(meas_valid), 32'd0);
    tick(27); pwm_in = 1'b0; tick(40);
    pwm_in = 1'b1; tick(3);
    chk("t5_valid",  32'(meas_valid),  32'd1);
    chk("t5_period", 32'(meas_period), 32'd70);
    chk("t5_high",   32'(meas_high),   32'd30);
    meas_ack = 1'b1; tick(1); meas_ack = 1'b0;
    $display("txn t5 re-enable period=%0d high=%0d", meas_period, meas_high);

    // 6: saturation with a 70000-cycle period, then reset pulsed mid-LOW
    tick(26); pwm_in = 1'b0; tick(69970);
    pwm_in = 1'b1; tick(3);
    chk("t6_sat_valid",  32'(meas_valid),  32'd1);
    chk("t6_sat_period", 32'(meas_period), 32'hFFFF);
    chk("t6_sat_high",   32'(meas_high),   32'd30);
    $display("txn t6 saturated period=%0h high=%0d", meas_period, meas_high);
    meas_ack = 1'b1; tick(1); meas_ack = 1'b0;
    tick(26); pwm_in = 1'b0; tick(20);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_period",  32'(meas_period),  32'd0);
    chk("t6_rst_high",    32'(meas_high),    32'd0);
    chk("t6_rst_valid",   32'(meas_valid),   32'd0);
    chk("t6_rst_overrun", 32'(meas_overrun), 32'd0);
    chk("t6_rst_timeout", 32'(meas_timeout), 32'd0);
    chk("t6_rst_busy",    32'(busy),         32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    pwm_in = 1'b1; tick(3);
    chk("t6_fresh_rise_no_result", 32'(meas_valid), 32'd0);
    chk("t6_busy",                 32'(busy),       32'd1);
    tick(27); pwm_in = 1'b0; tick(50);
    pwm_in = 1'b1; tick(3);
    chk("t6_post_rst_valid",  32'(meas_valid),  32'd1);
    chk("t6_post_rst_period", 32'(meas_period), 32'd80);
    chk("t6_post_rst_high",   32'(meas_high),   32'd30);
    $display("txn t6 post-reset period=%0d high=%0d", meas_period, meas_high);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
